frontend_cmd_arbiter: RTL and testbench
=======================================

FRONTEND_CMD_ARBITER -- requirements
Module: frontend_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter CMD_W, default 32, meaning width of one frontend command beat.
REQ-003 The block SHALL have parameter THROTTLE_ON_AF, default 1, meaning that when it is 1, new bursts are blocked while the FIFO is almost full.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port i_req_valid, input, NUM_REQ bits: per-requester command valid.
REQ-007 The block SHALL have port i_req_cmd, input, NUM_REQ*CMD_W bits: per-requester command, with requester k at bits [k*CMD_W +: CMD_W].
REQ-008 The block SHALL have port i_req_last, input, NUM_REQ bits: the beat is the final beat of its burst.
REQ-009 The block SHALL have port o_req_ready, output, NUM_REQ bits: beat accepted this cycle (at most one bit set).
REQ-010 The block SHALL have port o_fifo_wr_en, output, 1 bit: write strobe to the command FIFO.
REQ-011 The block SHALL have port o_fifo_wdata, output, CMD_W bits: data written to the FIFO.
REQ-012 The block SHALL have port i_fifo_full, input, 1 bit: FIFO full flag.
REQ-013 The block SHALL have port i_fifo_almost_full, input, 1 bit: FIFO almost-full flag.
REQ-014 The block SHALL have port o_grant_id, output, $clog2(NUM_REQ) bits: the current or last granted requester.
REQ-015 The block SHALL have port o_locked, output, 1 bit: a multi-beat burst is in progress.

Function
REQ-016 The block SHALL define an accept as o_req_ready[k]=1 with o_fifo_wr_en=1 and o_fifo_wdata=cmd[k], all in the same cycle, with zero latency.
REQ-017 The block SHALL assert o_fifo_wr_en only when i_fifo_full=0, and SHALL never assert it without a valid granted request.
REQ-018 The block SHALL implement a state machine with states IDLE and LOCKED.
REQ-019 In IDLE, the block SHALL grant the first valid requester at or after rr_ptr, scanning upward with modulo-NUM_REQ wrap.
REQ-020 In IDLE, the block SHALL withhold the grant when i_fifo_full=1, or when THROTTLE_ON_AF=1 and i_fifo_almost_full=1.
REQ-021 In IDLE, when an accepted beat has last=0, the block SHALL move to LOCKED and latch grant_id.
REQ-022 In IDLE, when an accepted beat has last=1, the block SHALL stay in IDLE and set rr_ptr to grant_id+1 (mod NUM_REQ).
REQ-023 In LOCKED, only the requester at grant_id SHALL be eligible; the block SHALL ignore almost_full and gate only on i_fifo_full.
REQ-024 In LOCKED, the block SHALL leave requests from other requesters pending with no ready.
REQ-025 In LOCKED, on accept of a beat with last=1, the block SHALL return to IDLE and set rr_ptr to grant_id+1.
REQ-026 In LOCKED, when the locked requester deasserts valid, the block SHALL stay LOCKED and issue no write.
REQ-027 The block SHALL drive o_locked=1 exactly while the state is LOCKED.
REQ-028 o_grant_id SHALL hold its value between grants.
REQ-029 When i_fifo_full and almost_full both deassert in the same cycle, the block SHALL allow the grant in that same cycle.

Reset
REQ-030 On i_rst=1 at a clock edge, the block SHALL set state=IDLE, rr_ptr=0 and o_grant_id=0, and SHALL drop the lock of any burst in progress.
REQ-031 While i_rst=1, the block SHALL force o_req_ready=0 and o_fifo_wr_en=0 combinationally.
REQ-032 After reset, o_locked SHALL be 0 and o_fifo_wdata SHALL be 0.

Configuration
REQ-033 When the macro FRONTEND_ARB_STALL_CNT_EN is defined, the block SHALL add output o_stall_cnt, 32 bits.
REQ-034 o_stall_cnt SHALL increment in every cycle where any i_req_valid=1 and no accept occurs, SHALL saturate at 0xFFFF_FFFF, and SHALL reset to 0.
REQ-035 When FRONTEND_ARB_STALL_CNT_EN is undefined, the port and the counter SHALL be absent, with no other change in behaviour.

Structure
REQ-036 The arbiter state enum (ARB_IDLE, ARB_LOCKED) SHALL live in frontend_command_definition_pkg.
REQ-037 The CMD_W default constant SHALL also live in frontend_command_definition_pkg.
REQ-038 The rotating priority pick SHALL be one sub-module, rr_pick (inputs: request vector, rr_ptr; outputs: one-hot grant plus index), and SHALL be purely combinational.

Verification
REQ-039 The bench SHALL check: all 4 requesters valid with single-beat commands, FIFO never full -> grants 0,1,2,3,0 on consecutive cycles, one write per cycle.
REQ-040 The bench SHALL check: req1 sends a 3-beat burst (last on beat 3) while req0 stays valid -> three writes from req1, o_locked=1 for 2 cycles, then req0 granted next.
REQ-041 The bench SHALL check: i_fifo_full=1 for 5 cycles while req2 is valid -> o_fifo_wr_en=0 for those cycles, then req2 is written in the first cycle full=0.
REQ-042 The bench SHALL check: THROTTLE_ON_AF=1 with almost_full=1 mid-burst -> the burst completes, and no new burst starts until almost_full=0.
REQ-043 The bench SHALL check: i_rst=1 during beat 2 of a 4-beat burst -> next cycle state=IDLE, o_locked=0, and the first grant after reset goes to requester 0.
REQ-044 The bench SHALL check, with FRONTEND_ARB_STALL_CNT_EN defined: 7 cycles of valid with full=1 -> o_stall_cnt=7.

Source files
------------

// File: rtl/frontend_command_definition_pkg.sv
// rtl/frontend_command_definition_pkg.sv - shared arbiter state encoding and command defaults
//
// Purpose: state enum for the frontend command arbiter and the default command beat width.
// Ports:   none (package)
package frontend_command_definition_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int CMD_W_DEFAULT = 32;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
//
// Purpose: selects the first set request at or after i_ptr, scanning upward with wrap.
// Ports:
//   i_req   N-bit request vector
//   i_ptr   starting index of the scan
//   o_grant one-hot grant (all zero when no request)
//   o_idx   index of the granted request (0 when none)
//   o_any   at least one request present
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int off = 0; off < N; off++) begin
            j = (int'(i_ptr) + off) % N;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/frontend_cmd_arbiter.sv
// rtl/frontend_cmd_arbiter.sv - round-robin command arbiter with burst lock into a command FIFO
//
// Purpose: arbitrates NUM_REQ command sources into one FIFO write port. A multi-beat burst
//          keeps the grant until its last beat; new bursts rotate round-robin.
// Optional: macro FRONTEND_ARB_STALL_CNT_EN adds o_stall_cnt (saturating stall counter).
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req_valid/cmd/last per-requester beat valid, data, end-of-burst
//   o_req_ready          one-hot beat accept (zero latency)
//   o_fifo_wr_en/wdata   FIFO write strobe and data (data is 0 when not writing)
//   i_fifo_full/almost_full  FIFO back-pressure
//   o_grant_id           current or last granted requester
//   o_locked             multi-beat burst in progress
//   o_stall_cnt          (optional) cycles with a valid request but no accept
module frontend_cmd_arbiter
    import frontend_command_definition_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int CMD_W          = CMD_W_DEFAULT,
    parameter int THROTTLE_ON_AF = 1,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*CMD_W-1:0] i_req_cmd,
    input  logic [NUM_REQ-1:0]       i_req_last,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_fifo_wr_en,
    output logic [CMD_W-1:0]         o_fifo_wdata,
    input  logic                     i_fifo_full,
    input  logic                     i_fifo_almost_full,
    output logic [IDX_W-1:0]         o_grant_id,
`ifdef FRONTEND_ARB_STALL_CNT_EN
    output logic [31:0]              o_stall_cnt,
`endif
    output logic                     o_locked
);

    arb_state_t         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]   r_grant_id, w_grant_id_nxt;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]   w_sel_inc;
    logic               w_accept;
    logic               w_throttle;

    assign w_throttle = (THROTTLE_ON_AF != 0) && i_fifo_almost_full;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_sel_oh       = '0;
        w_sel_idx      = r_grant_id;
        w_accept       = 1'b0;
        o_req_ready    = '0;
        o_fifo_wr_en   = 1'b0;
        o_fifo_wdata   = '0;

        case (r_state)
            ARB_IDLE: begin
                w_sel_oh  = w_pick_oh;
                w_sel_idx = w_pick_idx;
                w_accept  = w_pick_any && !i_fifo_full && !w_throttle;
            end
            ARB_LOCKED: begin
                // Almost-full only throttles new bursts; an open burst drains until full.
                w_sel_oh[r_grant_id] = 1'b1;
                w_accept             = i_req_valid[r_grant_id] && !i_fifo_full;
            end
            default: ;
        endcase

        if (i_rst) begin
            w_accept = 1'b0;
        end

        w_sel_inc = (w_sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel_idx + 1'b1;

        if (w_accept) begin
            o_req_ready    = w_sel_oh;
            o_fifo_wr_en   = 1'b1;
            w_grant_id_nxt = w_sel_idx;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_sel_oh[k]) begin
                    o_fifo_wdata = i_req_cmd[k*CMD_W +: CMD_W];
                end
            end
            if (i_req_last[w_sel_idx]) begin
                w_state_nxt  = ARB_IDLE;
                w_rr_ptr_nxt = w_sel_inc;
            end else begin
                w_state_nxt  = ARB_LOCKED;
            end
        end
    end

    assign o_grant_id = r_grant_id;
    assign o_locked   = (r_state == ARB_LOCKED);

`ifdef FRONTEND_ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if ((|i_req_valid) && !w_accept && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_frontend_cmd_arbiter.sv
// tb/tb_frontend_cmd_arbiter.sv - self-checking bench for frontend_cmd_arbiter
module tb_frontend_cmd_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   last = '0;
    logic [N*W-1:0] cmd = '0;
    logic           full = 1'b0;
    logic           af = 1'b0;
    logic [N-1:0]   ready;
    logic           wr_en;
    logic [W-1:0]   wdata;
    logic [IW-1:0]  gid;
    logic           locked;
`ifdef FRONTEND_ARB_STALL_CNT_EN
    logic [31:0]    stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bit          model_on = 1'b0;
    bit          m_locked;
    int          m_gid;
    int          m_ptr;
    longint      m_stall;

    frontend_cmd_arbiter #(
        .NUM_REQ        (N),
        .CMD_W          (W),
        .THROTTLE_ON_AF (1)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req_valid        (valid),
        .i_req_cmd          (cmd),
        .i_req_last         (last),
        .o_req_ready        (ready),
        .o_fifo_wr_en       (wr_en),
        .o_fifo_wdata       (wdata),
        .i_fifo_full        (full),
        .i_fifo_almost_full (af),
        .o_grant_id         (gid),
`ifdef FRONTEND_ARB_STALL_CNT_EN
        .o_stall_cnt        (stall_cnt),
`endif
        .o_locked           (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fixed_cmds();
        for (int k = 0; k < N; k++) cmd[k*W +: W] = 32'hC0DE_0000 + k;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        last  = '0;
        full  = 1'b0;
        af    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model: evaluated at the falling edge, when inputs are stable for the next rising edge.
    always @(negedge clk) begin
        int           acc;
        int           j;
        logic [N-1:0] e_ready;
        logic [W-1:0] e_wdata;
        if (model_on) begin
            acc = -1;
            if (!rst) begin
                if (m_locked) begin
                    if (valid[m_gid] && !full) acc = m_gid;
                end else if (!full && !af) begin
                    for (int off = 0; off < N; off++) begin
                        j = (m_ptr + off) % N;
                        if (acc < 0 && valid[j]) acc = j;
                    end
                end
            end
            e_ready = (acc >= 0) ? (N'(1) << acc) : '0;
            e_wdata = (acc >= 0) ? cmd[acc*W +: W] : '0;
            chk("m_ready",    64'(ready),  64'(e_ready));
            chk("m_wr_en",    64'(wr_en),  64'(acc >= 0));
            chk("m_wdata",    64'(wdata),  64'(e_wdata));
            chk("m_grant_id", 64'(gid),    64'(m_gid));
            chk("m_locked",   64'(locked), 64'(m_locked));
`ifdef FRONTEND_ARB_STALL_CNT_EN
            chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
            if (rst) begin
                m_locked = 1'b0;
                m_gid    = 0;
                m_ptr    = 0;
                m_stall  = 0;
            end else begin
                if ((|valid) && acc < 0 && m_stall != 64'hFFFF_FFFF) m_stall++;
                if (acc >= 0) begin
                    m_gid = acc;
                    if (last[acc]) begin
                        m_locked = 1'b0;
                        m_ptr    = (acc + 1) % N;
                    end else begin
                        m_locked = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        set_fixed_cmds();
        tick();
        m_locked = 1'b0;
        m_gid    = 0;
        m_ptr    = 0;
        m_stall  = 0;
        model_on = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_wdata",  64'(wdata),  64'd0);
        chk("rst_gid",    64'(gid),    64'd0);
        tick();

        // All four single-beat requesters: strict rotation 0,1,2,3,0
        begin
            int seq[5] = '{0, 1, 2, 3, 0};
            do_reset();
            valid = 4'b1111;
            last  = 4'b1111;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("rr_ready", 64'(ready), 64'(N'(1) << seq[i]));
                chk("rr_wr_en", 64'(wr_en), 64'd1);
                chk("rr_wdata", 64'(wdata), 64'(32'hC0DE_0000 + seq[i]));
                tick();
            end
        end

        // Three-beat burst from req1 while req0 stays valid
        do_reset();
        valid = 4'b0001; last = 4'b0001;
        @(negedge clk); chk("b3_pre", 64'(ready), 64'b0001); tick();
        valid = 4'b0011; last = 4'b0001;
        @(negedge clk); chk("b3_beat1", 64'(ready), 64'b0010); chk("b3_lock1", 64'(locked), 64'd0); tick();
        @(negedge clk); chk("b3_beat2", 64'(ready), 64'b0010); chk("b3_lock2", 64'(locked), 64'd1); tick();
        last = 4'b0011;
        @(negedge clk); chk("b3_beat3", 64'(ready), 64'b0010); chk("b3_lock3", 64'(locked), 64'd1); tick();
        @(negedge clk); chk("b3_next", 64'(ready), 64'b0001); chk("b3_unlock", 64'(locked), 64'd0); tick();

        // FIFO full for five cycles, req2 written on the first non-full cycle
        do_reset();
        valid = 4'b0100; last = 4'b0100; full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("full_wr_en", 64'(wr_en), 64'd0); tick();
        end
        full = 1'b0;
        @(negedge clk);
        chk("full_rel_ready", 64'(ready), 64'b0100);
        chk("full_rel_wdata", 64'(wdata), 64'(32'hC0DE_0002));
        tick();

        // Almost-full mid-burst: burst completes, new burst waits for almost_full to drop
        do_reset();
        valid = 4'b0011; last = 4'b0010;
        @(negedge clk); chk("af_beat1", 64'(ready), 64'b0001); tick();
        af = 1'b1;
        @(negedge clk); chk("af_beat2", 64'(ready), 64'b0001); tick();
        last = 4'b0011;
        @(negedge clk); chk("af_beat3", 64'(ready), 64'b0001); tick();
        valid = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); chk("af_hold", 64'(wr_en), 64'd0); tick();
        end
        af = 1'b0;
        @(negedge clk); chk("af_release", 64'(ready), 64'b0010); tick();

        // Reset during beat 2 of a 4-beat burst
        do_reset();
        valid = 4'b0100; last = 4'b0000;
        @(negedge clk); chk("rb_beat1", 64'(ready), 64'b0100); tick();
        rst = 1'b1;
        @(negedge clk); chk("rb_rst_ready", 64'(ready), 64'd0); chk("rb_rst_wr", 64'(wr_en), 64'd0); tick();
        rst = 1'b0; valid = 4'b0101; last = 4'b0101;
        @(negedge clk);
        chk("rb_locked", 64'(locked), 64'd0);
        chk("rb_gid",    64'(gid),    64'd0);
        chk("rb_ready",  64'(ready),  64'b0001);
        tick();

`ifdef FRONTEND_ARB_STALL_CNT_EN
        do_reset();
        valid = 4'b0001; last = 4'b0001; full = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        valid = '0; full = 1'b0;
        @(negedge clk); chk("stall_cnt_7", 64'(stall_cnt), 64'd7); tick();
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            valid = N'($urandom);
            last  = N'($urandom | $urandom);
            full  = ($urandom_range(0, 4) == 0);
            af    = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < N; k++) cmd[k*W +: W] = $urandom;
            tick();
        end
        rst = 1'b0;
        valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
